pwl_act_lut_pipe: RTL

//  Parametrised, pipelined piecewise-linear activation unit for the LSTM datapath (sigmoid/tanh gates).

---
 rtl/pwl_act_lut_pipe_if.sv | 29 ++
 rtl/pwl_act_lut_pipe.sv | 115 +++++++++++
 2 files changed

// File: rtl/pwl_act_lut_pipe_if.sv
// Stream and table-write bundle for the piecewise-linear activation unit.
interface pwl_act_lut_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FRAC_W = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ADDR_W+FRAC_W-1:0] x;
    logic [1:0]               mode;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] y;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;

    modport master (
        output in_valid, x, mode, out_ready,
        output wr_en, wr_addr, wr_data,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, x, mode, out_ready,
        input  wr_en, wr_addr, wr_data,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/pwl_act_lut_pipe.sv
// Two-stage piecewise-linear activation: S1 table lookup, S2 interpolation.
module pwl_act_lut_pipe #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    pwl_act_lut_pipe_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PW    = DATA_W + FRAC_W + 2;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'((DEPTH - 1) / 2);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    localparam logic [1:0] M_WRAP   = 2'd1;
    localparam logic [1:0] M_SIGNED = 2'd2;

    logic signed [DATA_W-1:0] tab_q [DEPTH];

    logic signed [DATA_W-1:0] base_q, base_d;
    logic signed [DATA_W-1:0] next_q, next_d;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic [FRAC_W-1:0]        frac_q;
    logic                     v1_q;
    logic                     ov_q;

    logic                     en;
    logic                     accept;
    logic [ADDR_W-1:0]        idx;
    logic [ADDR_W-1:0]        nidx;

    logic signed [PW-1:0]     base_x;
    logic signed [PW-1:0]     next_x;
    logic signed [PW-1:0]     diff_x;
    logic signed [PW-1:0]     frac_x;
    logic signed [PW-1:0]     prod;

    assign idx    = bus.x[ADDR_W+FRAC_W-1:FRAC_W];
    assign en     = !ov_q || bus.out_ready;
    assign accept = bus.in_valid && en;

    assign bus.in_ready  = en;
    assign bus.out_valid = ov_q;
    assign bus.y         = y_q;

    always_comb begin
        nidx = idx + ONE;
        case (bus.mode)
            M_WRAP: begin
                nidx = idx + ONE;
            end
            // Top positive signed index holds; top raw index wraps to 0.
            M_SIGNED: begin
                if (idx == HALF) begin
                    nidx = idx;
                end else if (idx == LAST) begin
                    nidx = '0;
                end
            end
            default: begin
                if (idx == LAST) begin
                    nidx = LAST;
                end
            end
        endcase
    end

    assign base_d = tab_q[idx];
    assign next_d = tab_q[nidx];

    always_comb begin
        base_x = {{(PW-DATA_W){base_q[DATA_W-1]}}, base_q};
        next_x = {{(PW-DATA_W){next_q[DATA_W-1]}}, next_q};
        frac_x = {{(PW-FRAC_W){1'b0}}, frac_q};
        diff_x = next_x - base_x;
        prod   = diff_x * frac_x;
        // Result stays between base and next, so truncation is exact.
        y_d    = DATA_W'(base_x + (prod >>> FRAC_W));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_q[i] <= DATA_W'(i) << (DATA_W - ADDR_W);
            end
        end else if (bus.wr_en) begin
            tab_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q   <= 1'b0;
            ov_q   <= 1'b0;
            y_q    <= '0;
            base_q <= '0;
            next_q <= '0;
            frac_q <= '0;
        end else if (en) begin
            v1_q <= accept;
            if (accept) begin
                base_q <= base_d;
                next_q <= next_d;
                frac_q <= bus.x[FRAC_W-1:0];
            end
            ov_q <= v1_q;
            if (v1_q) begin
                y_q <= y_d;
            end
        end
    end
endmodule
